rdma_rc_responder: RTL and testbench

- Responder side of the RC request path: consumes inbound request packets (64-bit beat stream, header beat first), checks QPN and PSN, forwards accepted payload to the host side, and generates ACK/NAK beats back toward the transmit path.
- Sits between the RX stage and the host delivery interface.
- Feeds a single-beat acknowledge stream into the TX arbitration point.

---
 rtl/rdma_pkg.sv | 38 +++
 rtl/rdma_ack_coalesce.sv | 66 ++++++
 rtl/rdma_rc_responder.sv | 212 +++++++++++++++++++++
 tb/tb_rdma_rc_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rdma_pkg.sv
// Shared definitions for the RC responder: header field positions, opcode
// and syndrome codes, receive FSM states, and the ACK beat formatter.
package rdma_pkg;

  localparam int PSN_W = 24;
  localparam int QPN_W = 24;

  // Header beat layout
  localparam int HDR_OP_HI  = 63;
  localparam int HDR_OP_LO  = 56;
  localparam int HDR_PSN_HI = 55;
  localparam int HDR_PSN_LO = 32;
  localparam int HDR_QPN_HI = 31;
  localparam int HDR_QPN_LO = 8;

  // Opcodes
  localparam logic [7:0] OP_ACK     = 8'h11;
  localparam logic [7:0] OP_MAX_REQ = 8'h0B;

  // ACK/NAK syndromes
  localparam logic [7:0] SYN_ACK     = 8'h00;
  localparam logic [7:0] SYN_NAK_SEQ = 8'h60;
  localparam logic [7:0] SYN_NAK_INV = 8'h61;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } rx_state_e;

  // Build a complete acknowledge beat.
  function automatic logic [63:0] ack_beat(input logic [QPN_W-1:0] qpn,
                                           input logic [PSN_W-1:0] psn,
                                           input logic [7:0]       syn);
    return {OP_ACK, psn, qpn, syn};
  endfunction

endpackage

// File: rtl/rdma_ack_coalesce.sv
// ACK/NAK output stage: one output register plus one pending slot.
// A request goes straight to the output when the output is empty or being
// accepted this cycle; otherwise it lands in the pending slot. The pending
// slot keeps only the most relevant beat: a NAK replaces anything, an ACK
// replaces only an ACK, so a pending NAK is never lost to a later ACK.
//
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   req_valid   - new acknowledge beat this cycle
//   req_data    - the beat (syndrome in [7:0])
//   ack_valid   - output beat valid
//   ack_data    - output beat
//   ack_ready   - consumer accepts the output beat
module rdma_ack_coalesce
  import rdma_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [63:0] req_data,
  output logic        ack_valid,
  output logic [63:0] ack_data,
  input  logic        ack_ready
);

  logic        pend_vld;
  logic [63:0] pend_data;
  logic        out_free;
  logic        req_is_nak;
  logic        pend_is_nak;

  assign out_free    = !ack_valid || ack_ready;
  assign req_is_nak  = (req_data[7:0] != SYN_ACK);
  assign pend_is_nak = (pend_data[7:0] != SYN_ACK);

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_valid <= 1'b0;
      ack_data  <= '0;
      pend_vld  <= 1'b0;
      pend_data <= '0;
    end else if (out_free) begin
      if (pend_vld) begin
        // Older pending beat goes out first; a concurrent request refills the slot.
        ack_valid <= 1'b1;
        ack_data  <= pend_data;
        if (req_valid) begin
          pend_data <= req_data;
        end else begin
          pend_vld <= 1'b0;
        end
      end else if (req_valid) begin
        ack_valid <= 1'b1;
        ack_data  <= req_data;
      end else begin
        ack_valid <= 1'b0;
      end
    end else if (req_valid) begin
      if (!pend_vld || req_is_nak || !pend_is_nak) begin
        pend_vld  <= 1'b1;
        pend_data <= req_data;
      end
    end
  end

endmodule

// File: rtl/rdma_rc_responder.sv
// RC responder request path. Classifies each inbound header against the
// local QPN and expected PSN (ePSN), forwards in-order payload to the host
// one cycle after arrival, and generates ACK/NAK beats through a coalescing
// output stage.
//
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   cfg_qpn, cfg_init_psn     - local QP number, initial expected PSN
//   cfg_load                  - pulse: reload ePSN, disarm NAK, abort packet
//   in_valid/in_data/in_last  - inbound beat stream, header first
//   deliver_*                 - payload to host; err qualifies last (discard)
//   ack_valid/ack_data/ack_ready - acknowledge stream toward TX
//   stat_dup_cnt/stat_nak_cnt - saturating statistics
module rdma_rc_responder
  import rdma_pkg::*;
#(
  parameter int MAX_BEATS = 32,
  parameter int STAT_W    = 16
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [QPN_W-1:0]  cfg_qpn,
  input  logic [PSN_W-1:0]  cfg_init_psn,
  input  logic              cfg_load,
  input  logic              in_valid,
  input  logic [63:0]       in_data,
  input  logic              in_last,
  output logic              deliver_valid,
  output logic [63:0]       deliver_data,
  output logic              deliver_last,
  output logic              deliver_err,
  output logic              ack_valid,
  output logic [63:0]       ack_data,
  input  logic              ack_ready,
  output logic [STAT_W-1:0] stat_dup_cnt,
  output logic [STAT_W-1:0] stat_nak_cnt
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  rx_state_e        state;
  logic [PSN_W-1:0] epsn;
  logic             nak_armed;
  logic [CNT_W-1:0] beat_cnt;

  logic [7:0]       hdr_op;
  logic [PSN_W-1:0] hdr_psn;
  logic [QPN_W-1:0] hdr_qpn;
  logic [PSN_W-1:0] psn_diff;
  logic [PSN_W-1:0] epsn_inc;
  logic [PSN_W-1:0] epsn_dec;
  logic             hdr_beat;
  logic             pay_beat;
  logic             qpn_ok;
  logic             op_ok;
  logic             in_order;
  logic             is_dup;
  logic             overflow;

  logic             ack_req;
  logic [PSN_W-1:0] ack_psn;
  logic [7:0]       ack_syn;
  logic             nak_gen;

  assign hdr_op   = in_data[HDR_OP_HI:HDR_OP_LO];
  assign hdr_psn  = in_data[HDR_PSN_HI:HDR_PSN_LO];
  assign hdr_qpn  = in_data[HDR_QPN_HI:HDR_QPN_LO];
  assign psn_diff = hdr_psn - epsn;
  assign epsn_inc = epsn + 24'd1;
  assign epsn_dec = epsn - 24'd1;

  // cfg_load aborts whatever beat shares its cycle.
  assign hdr_beat = in_valid && !cfg_load && (state == ST_IDLE);
  assign pay_beat = in_valid && !cfg_load && (state == ST_PAYLOAD);
  assign qpn_ok   = (hdr_qpn == cfg_qpn);
  assign op_ok    = (hdr_op <= OP_MAX_REQ);
  assign in_order = (psn_diff == '0);
  // Upper half of the 24-bit PSN window is "behind" ePSN, i.e. a duplicate.
  assign is_dup   = psn_diff[PSN_W-1];
  assign overflow = (beat_cnt == CNT_W'(MAX_BEATS));

  // Acknowledge decision for the current beat.
  always_comb begin
    ack_req = 1'b0;
    ack_psn = epsn;
    ack_syn = SYN_ACK;
    if (hdr_beat && qpn_ok) begin
      if (!op_ok) begin
        ack_req = 1'b1;
        ack_syn = SYN_NAK_INV;
      end else if (in_order) begin
        ack_req = in_last;
      end else if (is_dup) begin
        ack_req = 1'b1;
        ack_psn = epsn_dec;
      end else if (!nak_armed) begin
        ack_req = 1'b1;
        ack_syn = SYN_NAK_SEQ;
      end
    end else if (pay_beat) begin
      if (overflow) begin
        ack_req = 1'b1;
        ack_syn = SYN_NAK_INV;
      end else begin
        ack_req = in_last;
      end
    end
  end

  assign nak_gen = ack_req && (ack_syn != SYN_ACK);

  // Receive FSM, PSN state, delivery register and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      epsn          <= '0;
      nak_armed     <= 1'b0;
      beat_cnt      <= '0;
      deliver_valid <= 1'b0;
      deliver_data  <= '0;
      deliver_last  <= 1'b0;
      deliver_err   <= 1'b0;
      stat_dup_cnt  <= '0;
      stat_nak_cnt  <= '0;
    end else begin
      deliver_valid <= 1'b0;
      deliver_last  <= 1'b0;
      deliver_err   <= 1'b0;
      if (nak_gen) begin
        stat_nak_cnt <= sat_inc(stat_nak_cnt);
      end
      if (cfg_load) begin
        epsn      <= cfg_init_psn;
        nak_armed <= 1'b0;
        // Close a partially delivered packet so the host can discard it.
        if (state == ST_PAYLOAD && beat_cnt != '0) begin
          deliver_valid <= 1'b1;
          deliver_data  <= '0;
          deliver_last  <= 1'b1;
          deliver_err   <= 1'b1;
        end
        // If the aborted beat was the packet's last, there is nothing left to drop.
        if (in_valid && in_last) begin
          state <= ST_IDLE;
        end else if (state != ST_IDLE || in_valid) begin
          state <= ST_DROP;
        end
      end else if (in_valid) begin
        case (state)
          ST_IDLE: begin
            beat_cnt <= '0;
            if (!qpn_ok || !op_ok) begin
              state <= in_last ? ST_IDLE : ST_DROP;
            end else if (in_order) begin
              nak_armed <= 1'b0;
              if (in_last) begin
                epsn  <= epsn_inc;
                state <= ST_IDLE;
              end else begin
                state <= ST_PAYLOAD;
              end
            end else begin
              if (is_dup) begin
                stat_dup_cnt <= sat_inc(stat_dup_cnt);
              end else begin
                nak_armed <= 1'b1;
              end
              state <= in_last ? ST_IDLE : ST_DROP;
            end
          end
          ST_PAYLOAD: begin
            deliver_valid <= 1'b1;
            deliver_data  <= in_data;
            if (overflow) begin
              deliver_last <= 1'b1;
              deliver_err  <= 1'b1;
              state        <= in_last ? ST_IDLE : ST_DROP;
            end else begin
              deliver_last <= in_last;
              beat_cnt     <= beat_cnt + CNT_W'(1);
              if (in_last) begin
                epsn  <= epsn_inc;
                state <= ST_IDLE;
              end
            end
          end
          ST_DROP: begin
            if (in_last) begin
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  rdma_ack_coalesce u_ack (
    .clk       (clk),
    .rst       (rst),
    .req_valid (ack_req),
    .req_data  (ack_beat(cfg_qpn, ack_psn, ack_syn)),
    .ack_valid (ack_valid),
    .ack_data  (ack_data),
    .ack_ready (ack_ready)
  );

endmodule

// File: tb/tb_rdma_rc_responder.sv
module tb_rdma_rc_responder;
  import rdma_pkg::*;

  localparam int MAX_BEATS = 32;
  localparam int STAT_W    = 16;
  localparam logic [23:0] QPN = 24'h00ABCD;

  logic              clk = 1'b0;
  logic              rst;
  logic [23:0]       cfg_qpn;
  logic [23:0]       cfg_init_psn;
  logic              cfg_load;
  logic              in_valid;
  logic [63:0]       in_data;
  logic              in_last;
  logic              deliver_valid;
  logic [63:0]       deliver_data;
  logic              deliver_last;
  logic              deliver_err;
  logic              ack_valid;
  logic [63:0]       ack_data;
  logic              ack_ready;
  logic [STAT_W-1:0] stat_dup_cnt;
  logic [STAT_W-1:0] stat_nak_cnt;

  rdma_rc_responder #(.MAX_BEATS(MAX_BEATS), .STAT_W(STAT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_qpn       (cfg_qpn),
    .cfg_init_psn  (cfg_init_psn),
    .cfg_load      (cfg_load),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_last       (in_last),
    .deliver_valid (deliver_valid),
    .deliver_data  (deliver_data),
    .deliver_last  (deliver_last),
    .deliver_err   (deliver_err),
    .ack_valid     (ack_valid),
    .ack_data      (ack_data),
    .ack_ready     (ack_ready),
    .stat_dup_cnt  (stat_dup_cnt),
    .stat_nak_cnt  (stat_nak_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cyc;
    logic [63:0] data;
    logic        last;
    logic        err;
  } dlv_t;

  dlv_t        dq[$];
  logic [63:0] aq[$];
  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int exp_nak = 0;
  int exp_dup = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors, sampled on the inactive edge.
  always @(negedge clk) begin
    if (!rst && deliver_valid) begin
      if (dq.size() == 0) begin
        check("deliver_unexpected", {64'd0, deliver_data}, 128'd0);
      end else begin
        dlv_t e;
        e = dq.pop_front();
        check("deliver", {32'(cyc), deliver_data, deliver_last, deliver_err},
              {e.cyc, e.data, e.last, e.err});
      end
    end
    if (!rst && ack_valid && ack_ready) begin
      if (aq.size() == 0) begin
        check("ack_unexpected", {64'd0, ack_data}, 128'd0);
      end else begin
        logic [63:0] a;
        a = aq.pop_front();
        check("ack", {64'd0, ack_data}, {64'd0, a});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  function automatic logic [63:0] pay(input logic [23:0] psn, input int i);
    return {8'hD0, psn, 16'hBEEF, 16'(i)};
  endfunction

  // Header plus n payload beats; when acc is set, the expected deliveries
  // (including the truncating beat on overflow) are queued.
  task automatic send_pkt(input logic [7:0] op, input logic [23:0] psn,
                          input logic [23:0] qpn, input int n, input bit acc);
    dlv_t e;
    send_beat({op, psn, qpn, 8'h00}, n == 0);
    for (int i = 0; i < n; i++) begin
      if (acc && i <= MAX_BEATS) begin
        e.cyc  = 32'(cyc + 1);
        e.data = pay(psn, i);
        e.last = (i == MAX_BEATS) ? 1'b1 : (i == n - 1);
        e.err  = (i == MAX_BEATS);
        dq.push_back(e);
      end
      send_beat(pay(psn, i), i == n - 1);
    end
  endtask

  task automatic exp_ack(input logic [23:0] psn, input logic [7:0] syn);
    aq.push_back({8'h11, psn, QPN, syn});
  endtask

  task automatic load(input logic [23:0] psn);
    cfg_init_psn = psn;
    cfg_load     = 1'b1;
    tick();
    cfg_load     = 1'b0;
  endtask

  task automatic drain(input string tag, input int n);
    repeat (n) tick();
    check({tag, "_deliver_left"}, 128'(dq.size()), 128'd0);
    check({tag, "_ack_left"}, 128'(aq.size()), 128'd0);
  endtask

  initial begin
    dlv_t e;
    rst = 1'b1; cfg_qpn = QPN; cfg_init_psn = '0; cfg_load = 1'b0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; ack_ready = 1'b1;
    repeat (3) tick();
    check("rst_deliver_valid", 128'(deliver_valid), 128'd0);
    check("rst_deliver_data", 128'(deliver_data), 128'd0);
    check("rst_ack_valid", 128'(ack_valid), 128'd0);
    check("rst_ack_data", 128'(ack_data), 128'd0);
    check("rst_stats", {96'd0, stat_dup_cnt, stat_nak_cnt}, 128'd0);
    rst = 1'b0;
    tick();

    // In-order packets, header + 3 payload beats each.
    load(24'h000010);
    exp_ack(24'h10, SYN_ACK);
    send_pkt(8'h04, 24'h10, QPN, 3, 1'b1);
    check("ack_latency_valid", 128'(ack_valid), 128'd1);
    check("ack_latency_data", 128'(ack_data), {64'd0, 8'h11, 24'h10, QPN, 8'h00});
    exp_ack(24'h11, SYN_ACK);
    send_pkt(8'h04, 24'h11, QPN, 3, 1'b1);
    exp_ack(24'h12, SYN_ACK);
    send_pkt(8'h04, 24'h12, QPN, 3, 1'b1);
    exp_ack(24'h13, SYN_ACK);
    send_pkt(8'h04, 24'h13, QPN, 0, 1'b1);
    drain("inorder", 6);

    // PSN wrap.
    load(24'hFFFFFF);
    exp_ack(24'hFFFFFF, SYN_ACK);
    send_pkt(8'h04, 24'hFFFFFF, QPN, 2, 1'b1);
    exp_ack(24'h000000, SYN_ACK);
    send_pkt(8'h04, 24'h000000, QPN, 2, 1'b1);
    exp_ack(24'h000001, SYN_ACK);
    send_pkt(8'h04, 24'h000001, QPN, 0, 1'b1);
    drain("wrap", 6);

    // Sequence gap: one NAK, then silence until the expected PSN arrives.
    load(24'h20);
    exp_ack(24'h20, SYN_NAK_SEQ); exp_nak++;
    send_pkt(8'h04, 24'h22, QPN, 2, 1'b0);
    send_pkt(8'h04, 24'h23, QPN, 2, 1'b0);
    exp_ack(24'h20, SYN_ACK);
    send_pkt(8'h04, 24'h20, QPN, 2, 1'b1);
    drain("nakseq", 6);
    check("nakseq_stat_nak", 128'(stat_nak_cnt), 128'(exp_nak));

    // Duplicate.
    load(24'h20);
    exp_ack(24'h1F, SYN_ACK); exp_dup++;
    send_pkt(8'h04, 24'h1E, QPN, 2, 1'b0);
    drain("dup", 6);
    check("dup_stat_dup", 128'(stat_dup_cnt), 128'(exp_dup));

    // Backpressure: ACK 5 held, ACK 6 coalesced by ACK 7.
    ack_ready = 1'b0;
    load(24'h5);
    exp_ack(24'h5, SYN_ACK);
    exp_ack(24'h7, SYN_ACK);
    send_pkt(8'h04, 24'h5, QPN, 1, 1'b1);
    send_pkt(8'h04, 24'h6, QPN, 1, 1'b1);
    send_pkt(8'h04, 24'h7, QPN, 1, 1'b1);
    repeat (3) tick();
    check("stall_valid", 128'(ack_valid), 128'd1);
    check("stall_hold", 128'(ack_data), {64'd0, 8'h11, 24'h5, QPN, 8'h00});
    ack_ready = 1'b1;
    drain("stall", 6);

    // A pending NAK replaces a pending ACK and is not replaced by a later ACK.
    ack_ready = 1'b0;
    load(24'h40);
    exp_ack(24'h40, SYN_NAK_SEQ); exp_nak++;
    exp_ack(24'h41, SYN_NAK_SEQ); exp_nak++;
    send_pkt(8'h04, 24'h41, QPN, 1, 1'b0);
    send_pkt(8'h04, 24'h40, QPN, 1, 1'b1);
    send_pkt(8'h04, 24'h45, QPN, 1, 1'b0);
    send_pkt(8'h04, 24'h41, QPN, 0, 1'b1);
    tick();
    ack_ready = 1'b1;
    drain("nakprio", 6);
    exp_ack(24'h42, SYN_ACK);
    send_pkt(8'h04, 24'h42, QPN, 0, 1'b1);
    drain("nakprio_probe", 4);

    // Overflow: 40 payload beats, ePSN stays put.
    load(24'h30);
    exp_ack(24'h30, SYN_NAK_INV); exp_nak++;
    send_pkt(8'h04, 24'h30, QPN, 40, 1'b1);
    drain("overflow", 4);
    exp_ack(24'h30, SYN_ACK);
    send_pkt(8'h04, 24'h30, QPN, 0, 1'b1);
    // Invalid opcode, then a foreign-QPN packet that must leave no trace.
    exp_ack(24'h31, SYN_NAK_INV); exp_nak++;
    send_pkt(8'h0C, 24'h99, QPN, 0, 1'b0);
    send_pkt(8'h04, 24'h31, 24'h123456, 3, 1'b0);
    exp_ack(24'h31, SYN_ACK);
    send_pkt(8'h04, 24'h31, QPN, 0, 1'b1);
    drain("badop_qpn", 6);

    // cfg_load mid-packet closes the delivered part with an error beat.
    load(24'h50);
    send_beat({8'h04, 24'h50, QPN, 8'h00}, 1'b0);
    e.cyc = 32'(cyc + 1); e.data = pay(24'h50, 0); e.last = 1'b0; e.err = 1'b0;
    dq.push_back(e);
    send_beat(pay(24'h50, 0), 1'b0);
    e.cyc = 32'(cyc + 1); e.data = '0; e.last = 1'b1; e.err = 1'b1;
    dq.push_back(e);
    load(24'h60);
    send_beat(pay(24'h50, 1), 1'b0);
    send_beat(pay(24'h50, 2), 1'b1);
    exp_ack(24'h60, SYN_ACK);
    send_pkt(8'h04, 24'h60, QPN, 0, 1'b1);
    drain("midload", 6);

    check("final_stat_nak", 128'(stat_nak_cnt), 128'(exp_nak));
    check("final_stat_dup", 128'(stat_dup_cnt), 128'(exp_dup));

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
